uart_fifo: RTL and testbench

Parametrised UART with independent TX and RX FIFOs, an internal baud generator and an oversampled receiver. It is the next-generation peripheral for the MIPS32 processor's memory-mapped I/O. FIFOs let the core queue several words and drain received data in bursts instead of polling per character. Receive errors (framing, overrun) are reported through sticky status flags.

---
 rtl/uart_fifo.sv | 397 +++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: UART with TX/RX FIFOs, internal baud generator and an
// oversampled receiver with sticky framing/overrun error flags.
//
// Ports:
//   clk, reset      : clock (rising edge), synchronous active-high reset
//   txData, txWrite : enqueue a word for transmission
//   txFull, txIdle  : TX FIFO full / FIFO empty and line idle
//   tx, rx          : serial out (idle high) / serial in (asynchronous)
//   rxRead          : pop the RX FIFO head
//   rxData, rxEmpty : RX FIFO head (first-word fall-through) / empty
//   rxFrameErr      : sticky, stop bit sampled low
//   rxOverrun       : sticky, word dropped because RX FIFO was full
//   rxClear         : clears the sticky flags
// Optional: define UART_PARITY_EN to add a parity bit to every frame,
//   the parityOdd input (1=odd, 0=even) and the sticky rxParityErr output.
module uart_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] txData,
  input  logic                 txWrite,
  output logic                 txFull,
  output logic                 txIdle,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 rxRead,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxEmpty,
  output logic                 rxFrameErr,
  output logic                 rxOverrun,
  input  logic                 rxClear
`ifdef UART_PARITY_EN
  ,
  input  logic                 parityOdd,
  output logic                 rxParityErr
`endif
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  // ---------------- baud generator ----------------
  logic [DW-1:0] divCnt;
  logic [OW-1:0] osCnt;
  logic          rxTick;
  logic          txTick;

  assign rxTick = (divCnt == DW'(DIV - 1));
  assign txTick = rxTick && (osCnt == OW'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt <= '0;
      osCnt  <= '0;
    end else begin
      divCnt <= rxTick ? '0 : divCnt + 1'b1;
      if (rxTick)
        osCnt <= txTick ? '0 : osCnt + 1'b1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] txMem [FIFO_DEPTH];
  logic [PW-1:0]        txWr;
  logic [PW-1:0]        txRd;
  logic                 txEmpty;
  logic                 txPush;
  logic                 txPop;
  logic [DATA_BITS-1:0] txHead;

  assign txFull  = (txWr[AW] != txRd[AW]) &&
                   (txWr[AW-1:0] == txRd[AW-1:0]);
  assign txEmpty = (txWr == txRd);
  assign txPush  = txWrite && !txFull;
  assign txHead  = txMem[txRd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (txPush)
      txMem[txWr[AW-1:0]] <= txData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txWr <= '0;
      txRd <= '0;
    end else begin
      if (txPush) txWr <= txWr + 1'b1;
      if (txPop)  txRd <= txRd + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
`ifdef UART_PARITY_EN
    , TX_PARITY
`endif
  } txState_t;

  txState_t             txState;
  txState_t             txStateNext;
  logic [DATA_BITS-1:0] txShift;
  logic [BW-1:0]        txBitCnt;
  logic                 txLast;
`ifdef UART_PARITY_EN
  logic                 txPar;
`endif

  assign txLast = (txBitCnt == BW'(DATA_BITS - 1));
  assign txIdle = txEmpty && (txState == TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) txState <= TX_IDLE;
    else       txState <= txStateNext;
  end

  always_comb begin
    txStateNext = txState;
    txPop       = 1'b0;
    unique case (txState)
      TX_IDLE: begin
        if (txTick && !txEmpty) begin
          txPop       = 1'b1;
          txStateNext = TX_START;
        end
      end
      TX_START: begin
        if (txTick) txStateNext = TX_DATA;
      end
      TX_DATA: begin
`ifdef UART_PARITY_EN
        if (txTick && txLast) txStateNext = TX_PARITY;
`else
        if (txTick && txLast) txStateNext = TX_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (txTick) txStateNext = TX_STOP;
      end
`endif
      TX_STOP: begin
        // Chain straight into the next start bit when more data waits.
        if (txTick) begin
          if (!txEmpty) begin
            txPop       = 1'b1;
            txStateNext = TX_START;
          end else begin
            txStateNext = TX_IDLE;
          end
        end
      end
      default: txStateNext = TX_IDLE;
    endcase
  end

  // tx is registered: each txTick sets the bit for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx       <= 1'b1;
      txShift  <= '0;
      txBitCnt <= '0;
`ifdef UART_PARITY_EN
      txPar    <= 1'b0;
`endif
    end else if (txTick) begin
      if (txPop) begin
        tx       <= 1'b0;
        txShift  <= txHead;
        txBitCnt <= '0;
`ifdef UART_PARITY_EN
        txPar    <= (^txHead) ^ parityOdd;
`endif
      end else begin
        case (txState)
          TX_START: tx <= txShift[0];
          TX_DATA: begin
            if (!txLast) begin
              tx       <= txShift[1];
              txShift  <= {1'b0, txShift[DATA_BITS-1:1]};
              txBitCnt <= txBitCnt + 1'b1;
            end else begin
`ifdef UART_PARITY_EN
              tx <= txPar;
`else
              tx <= 1'b1;
`endif
            end
          end
          default: tx <= 1'b1;
        endcase
      end
    end
  end

  // ---------------- RX synchroniser ----------------
  logic [1:0] rxSync;
  logic       rxS;
  logic       rxPrev;
  logic       rxFall;

  assign rxS    = rxSync[1];
  assign rxFall = rxPrev && !rxS;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxSync <= 2'b11;
      rxPrev <= 1'b1;
    end else begin
      rxSync <= {rxSync[0], rx};
      rxPrev <= rxS;
    end
  end

  // ---------------- RX FSM ----------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
`ifdef UART_PARITY_EN
    , RX_PARITY
`endif
  } rxState_t;

  rxState_t             rxState;
  rxState_t             rxStateNext;
  logic [OW-1:0]        rxTickCnt;
  logic [OW-1:0]        rxTickEnd;
  logic [BW-1:0]        rxBitCnt;
  logic [DATA_BITS-1:0] rxShift;
  logic                 rxErrWait;
  logic                 rxSampleNow;
  logic                 rxPush;
  logic                 frameErrSet;
`ifdef UART_PARITY_EN
  logic                 rxParOdd;
  logic                 parErrSet;
`endif

  // Start bit is checked at its middle; later bits one full bit apart.
  assign rxTickEnd = (rxState == RX_START) ?
                     OW'(OVERSAMPLE / 2 - 1) : OW'(OVERSAMPLE - 1);
  assign rxSampleNow = rxTick && (rxTickCnt == rxTickEnd);

  always_ff @(posedge clk) begin
    if (reset) rxState <= RX_IDLE;
    else       rxState <= rxStateNext;
  end

  always_comb begin
    rxStateNext = rxState;
    rxPush      = 1'b0;
    frameErrSet = 1'b0;
`ifdef UART_PARITY_EN
    parErrSet   = 1'b0;
`endif
    unique case (rxState)
      RX_IDLE: begin
        if (rxFall) rxStateNext = RX_START;
      end
      RX_START: begin
        if (rxSampleNow)
          rxStateNext = rxS ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rxSampleNow && (rxBitCnt == BW'(DATA_BITS - 1)))
`ifdef UART_PARITY_EN
          rxStateNext = RX_PARITY;
`else
          rxStateNext = RX_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rxSampleNow) begin
          parErrSet   = (rxS != ((^rxShift) ^ rxParOdd));
          rxStateNext = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        // After a framing error, wait for the line to go high so the
        // low stop bit is not mistaken for a new start edge.
        if (rxErrWait) begin
          if (rxS) rxStateNext = RX_IDLE;
        end else if (rxSampleNow) begin
          if (rxS) begin
            rxPush      = 1'b1;
            rxStateNext = RX_IDLE;
          end else begin
            frameErrSet = 1'b1;
          end
        end
      end
      default: rxStateNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxTickCnt <= '0;
      rxBitCnt  <= '0;
      rxShift   <= '0;
      rxErrWait <= 1'b0;
`ifdef UART_PARITY_EN
      rxParOdd  <= 1'b0;
`endif
    end else begin
      if (rxState == RX_IDLE || rxSampleNow)
        rxTickCnt <= '0;
      else if (rxTick)
        rxTickCnt <= rxTickCnt + 1'b1;
      if (rxState == RX_START)
        rxBitCnt <= '0;
      if (rxState == RX_DATA && rxSampleNow) begin
        rxShift  <= {rxS, rxShift[DATA_BITS-1:1]};
        rxBitCnt <= rxBitCnt + 1'b1;
      end
      if (frameErrSet)
        rxErrWait <= 1'b1;
      else if (rxStateNext == RX_IDLE)
        rxErrWait <= 1'b0;
`ifdef UART_PARITY_EN
      if (rxState == RX_IDLE && rxFall)
        rxParOdd <= parityOdd;
`endif
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rxMem [FIFO_DEPTH];
  logic [PW-1:0]        rxWr;
  logic [PW-1:0]        rxRd;
  logic                 rxFull;
  logic                 rxPop;
  logic                 rxWrEn;
  logic                 overrunSet;

  assign rxFull  = (rxWr[AW] != rxRd[AW]) &&
                   (rxWr[AW-1:0] == rxRd[AW-1:0]);
  assign rxEmpty = (rxWr == rxRd);
  assign rxPop   = rxRead && !rxEmpty;
  // A pop in the same cycle frees the slot the new word lands in.
  assign rxWrEn     = rxPush && (!rxFull || rxRead);
  assign overrunSet = rxPush && rxFull && !rxRead;
  assign rxData     = rxEmpty ? '0 : rxMem[rxRd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rxWrEn)
      rxMem[rxWr[AW-1:0]] <= rxShift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxWr <= '0;
      rxRd <= '0;
    end else begin
      if (rxWrEn) rxWr <= rxWr + 1'b1;
      if (rxPop)  rxRd <= rxRd + 1'b1;
    end
  end

  // ---------------- sticky flags (set beats clear) ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rxFrameErr  <= 1'b0;
      rxOverrun   <= 1'b0;
`ifdef UART_PARITY_EN
      rxParityErr <= 1'b0;
`endif
    end else begin
      if (frameErrSet)  rxFrameErr <= 1'b1;
      else if (rxClear) rxFrameErr <= 1'b0;
      if (overrunSet)   rxOverrun <= 1'b1;
      else if (rxClear) rxOverrun <= 1'b0;
`ifdef UART_PARITY_EN
      if (parErrSet)    rxParityErr <= 1'b1;
      else if (rxClear) rxParityErr <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo at 16 clocks per bit.
// Frames are decoded/driven by the bench with hand-computed values.
module tb_uart_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] txData = 8'h00;
  logic       txWrite = 1'b0;
  logic       txFull;
  logic       txIdle;
  logic       tx;
  logic       rxIn;
  logic       rxRead = 1'b0;
  logic [7:0] rxData;
  logic       rxEmpty;
  logic       rxFrameErr;
  logic       rxOverrun;
  logic       rxClear = 1'b0;

  logic loopBack = 1'b0;
  logic rxLine = 1'b1;
  assign rxIn = loopBack ? tx : rxLine;

  uart_fifo #(
    .CLK_FREQ(1600000),
    .BAUD(100000),
    .OVERSAMPLE(16),
    .DATA_BITS(8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .txData(txData),
    .txWrite(txWrite),
    .txFull(txFull),
    .txIdle(txIdle),
    .tx(tx),
    .rx(rxIn),
    .rxRead(rxRead),
    .rxData(rxData),
    .rxEmpty(rxEmpty),
    .rxFrameErr(rxFrameErr),
    .rxOverrun(rxOverrun),
    .rxClear(rxClear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] txLog[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushTx(input logic [7:0] d);
    txData  = d;
    txWrite = 1'b1;
    tick(1);
    txWrite = 1'b0;
  endtask

  task automatic popRx();
    rxRead = 1'b1;
    tick(1);
    rxRead = 1'b0;
  endtask

  task automatic sendRx(input logic [7:0] d, input logic stopBit);
    rxLine = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxLine = d[i];
      tick(16);
    end
    rxLine = stopBit;
    tick(16);
    rxLine = 1'b1;
  endtask

  task automatic checkReset(input string pfx);
    check({pfx, " tx"}, tx, 1);
    check({pfx, " txFull"}, txFull, 0);
    check({pfx, " txIdle"}, txIdle, 1);
    check({pfx, " rxEmpty"}, rxEmpty, 1);
    check({pfx, " rxData"}, rxData, 0);
    check({pfx, " rxFrameErr"}, rxFrameErr, 0);
    check({pfx, " rxOverrun"}, rxOverrun, 0);
  endtask

  // Bench-side receiver on tx: samples mid-bit, stops after an idle gap.
  task automatic decodeTx();
    int w;
    logic [7:0] b;
    logic done;
    done = 1'b0;
    while (!done && txLog.size() < 20) begin
      w = 0;
      while (tx && w < 48) begin
        tick(1);
        w++;
      end
      if (w >= 48) begin
        done = 1'b1;
      end else begin
        b = 8'h00;
        tick(8);
        for (int i = 0; i < 8; i++) begin
          tick(16);
          b[i] = tx;
        end
        tick(16);
        check("t2 stop bit", tx, 1);
        txLog.push_back(b);
      end
    end
  endtask

  int n;
  int run;
  logic [7:0] pat;

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick(3);
    checkReset("reset");
    reset = 1'b0;
    tick(2);

    // 1: single frame 0xA5
    pat = 8'hA5;
    pushTx(pat);
    n = 0;
    while (tx && n < 64) begin
      tick(1);
      n++;
    end
    check("t1 start seen", n < 64, 1);
    run = 0;
    while (!tx && run < 64) begin
      tick(1);
      run++;
    end
    check("t1 start len", run, 16);
    check("t1 busy", txIdle, 0);
    tick(8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1 bit%0d", i), tx, pat[i]);
      tick(16);
    end
    check("t1 stop", tx, 1);
    tick(10);
    check("t1 idle", txIdle, 1);

    // 2: overfill TX FIFO while a frame is on the line
    txLog.delete();
    fork
      decodeTx();
      begin
        int m;
        pushTx(8'h11);
        m = 0;
        while (tx && m < 64) begin
          tick(1);
          m++;
        end
        check("t2 start seen", m < 64, 1);
        for (int k = 0; k < 17; k++) begin
          if (k == 15) check("t2 not full", txFull, 0);
          if (k == 16) check("t2 full", txFull, 1);
          txData  = 8'(8'h80 + k);
          txWrite = 1'b1;
          tick(1);
        end
        txWrite = 1'b0;
        check("t2 still full", txFull, 1);
      end
    join
    check("t2 frames", txLog.size(), 17);
    for (int i = 0; i < 17; i++) begin
      pat = (i == 0) ? 8'h11 : 8'(8'h80 + i - 1);
      check($sformatf("t2 frame%0d", i),
            (i < txLog.size()) ? {24'h0, txLog[i]} : 32'hFFFF, pat);
    end
    check("t2 idle", txIdle, 1);

    // 3: loopback 0x3C, 0xC3
    loopBack = 1'b1;
    pushTx(8'h3C);
    pushTx(8'hC3);
    n = 0;
    while (!txIdle && n < 1000) begin
      tick(1);
      n++;
    end
    check("t3 tx done", n < 1000, 1);
    tick(20);
    check("t3 not empty", rxEmpty, 0);
    check("t3 data0", rxData, 8'h3C);
    popRx();
    check("t3 data1", rxData, 8'hC3);
    popRx();
    check("t3 empty", rxEmpty, 1);
    check("t3 frameErr", rxFrameErr, 0);
    check("t3 overrun", rxOverrun, 0);
    loopBack = 1'b0;
    tick(5);

    // 4: glitch then valid 0x55
    rxLine = 1'b0;
    tick(4);
    rxLine = 1'b1;
    tick(30);
    check("t4 glitch empty", rxEmpty, 1);
    sendRx(8'h55, 1'b1);
    tick(8);
    check("t4 not empty", rxEmpty, 0);
    check("t4 data", rxData, 8'h55);
    check("t4 frameErr", rxFrameErr, 0);
    popRx();
    check("t4 empty", rxEmpty, 1);

    // 5: framing error on 0x12
    sendRx(8'h12, 1'b0);
    tick(8);
    check("t5 frameErr", rxFrameErr, 1);
    check("t5 empty", rxEmpty, 1);
    rxClear = 1'b1;
    tick(1);
    rxClear = 1'b0;
    check("t5 cleared", rxFrameErr, 0);

    // 6: fill RX FIFO, overrun, then reset mid-frame
    for (int i = 0; i < 16; i++) begin
      sendRx(8'(8'h40 + i), 1'b1);
      tick(2);
    end
    tick(8);
    check("t6 no overrun", rxOverrun, 0);
    check("t6 not empty", rxEmpty, 0);
    check("t6 head", rxData, 8'h40);
    sendRx(8'hEE, 1'b1);
    tick(8);
    check("t6 overrun", rxOverrun, 1);
    check("t6 head kept", rxData, 8'h40);
    check("t6 frameErr", rxFrameErr, 0);

    pushTx(8'h00);
    n = 0;
    while (tx && n < 64) begin
      tick(1);
      n++;
    end
    check("t6 tx busy", n < 64, 1);
    rxLine = 1'b0;
    tick(30);
    reset  = 1'b1;
    rxLine = 1'b1;
    tick(1);
    checkReset("t6 midreset");
    reset = 1'b0;
    tick(40);
    check("t6 tx quiet", tx, 1);
    check("t6 idle", txIdle, 1);
    check("t6 rx empty", rxEmpty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
